// File: rtl/decoder_pulse.sv
// -----------------------------------------------------------------------------
// decoder_pulse
//
// Registered 2-to-4 decoder that turns an accepted 2-bit code into a one-hot
// output pulse lasting HOLD_CYCLES clock cycles. Receiving end of the 4-to-2
// priority encoder path (or a switch bank), driving LED/enable lines.
//
// Parameters:
//   HOLD_CYCLES  cycles the decoded one-hot line stays high (legal 1..255)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   in0    in   code bit 0 (LSB)
//   in1    in   code bit 1 (MSB)
//   valid  in   {in1,in0} offered for acceptance this cycle
//   ack    out  one-cycle pulse in the cycle after a code is accepted
//   busy   out  high while a pulse is being held
//   out0   out  one-hot line for code 00
//   out1   out  one-hot line for code 01
//   out2   out  one-hot line for code 10
//   out3   out  one-hot line for code 11
//
// Configuration macro:
//   DECODER_PULSE_RETRIGGER_EN  when defined, valid during a pulse recaptures
//                               the code and restarts the pulse with no gap;
//                               when undefined, valid during a pulse is ignored.
// -----------------------------------------------------------------------------
module decoder_pulse #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic valid,
    output logic ack,
    output logic busy,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter reload: the HOLD state lasts reload+1 cycles.
    localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_r;
    logic [1:0]  code_r;
    logic [7:0]  cnt_r;
    logic        ack_r;
    logic        busy_r;
    logic [3:0]  out_r;
    logic [1:0]  code_s;

    assign code_s = {in1, in0};

    // One-hot decode of a 2-bit code; every code value maps to one line.
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        decode_onehot = 4'b0001 << code;
    endfunction

    // Pulse FSM; outputs are registered alongside state so no input reaches
    // an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            code_r  <= 2'b00;
            cnt_r   <= 8'd0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            out_r   <= 4'b0000;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid) begin
                        state_r <= HOLD;
                        code_r  <= code_s;
                        cnt_r   <= RELOAD;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        out_r   <= decode_onehot(code_s);
                    end else begin
                        busy_r  <= 1'b0;
                        out_r   <= 4'b0000;
                    end
                end
                HOLD: begin
`ifdef DECODER_PULSE_RETRIGGER_EN
                    // Retrigger wins over expiry so busy never drops.
                    if (valid) begin
                        code_r  <= code_s;
                        cnt_r   <= RELOAD;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        out_r   <= decode_onehot(code_s);
                    end else
`endif
                    if (cnt_r == 8'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        out_r   <= 4'b0000;
                    end else begin
                        // Decrement only while nonzero, so the counter never wraps.
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    out_r   <= 4'b0000;
                end
            endcase
        end
    end

    assign ack  = ack_r;
    assign busy = busy_r;
    assign out0 = out_r[0];
    assign out1 = out_r[1];
    assign out2 = out_r[2];
    assign out3 = out_r[3];

endmodule

// File: tb/tb_decoder_pulse.sv
// -----------------------------------------------------------------------------
// tb_decoder_pulse
//
// Drives two decoder_pulse instances (HOLD_CYCLES = 4 and 1) from the same
// inputs. Expected outputs come from a window model: an accepted code at edge
// s makes busy/out[code] high after edges s .. s+H-1 and ack high after edge s.
// -----------------------------------------------------------------------------
module tb_decoder_pulse;

    logic clk = 1'b0;
    logic rst, in0, in1, valid;

    logic ack_a, busy_a, o0_a, o1_a, o2_a, o3_a;
    logic ack_b, busy_b, o0_b, o1_b, o2_b, o3_b;

    int checks = 0;
    int errors = 0;

    // Model state: start edge of the current window and its code.
    int edge_n  = 0;
    int start_a = -1000;
    int start_b = -1000;
    int code_a  = 0;
    int code_b  = 0;

`ifdef DECODER_PULSE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    always #5 clk = ~clk;

    decoder_pulse #(.HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .valid(valid),
        .ack(ack_a), .busy(busy_a),
        .out0(o0_a), .out1(o1_a), .out2(o2_a), .out3(o3_a)
    );

    decoder_pulse #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .valid(valid),
        .ack(ack_b), .busy(busy_b),
        .out0(o0_b), .out1(o1_b), .out2(o2_b), .out3(o3_b)
    );

    function automatic logic [5:0] expect_vec(input int e, input int s,
                                              input int c, input int h);
        logic b;
        logic [3:0] oh;
        b  = (e >= s) && (e < s + h);
        oh = 4'b0000;
        if (b) oh[c] = 1'b1;
        return {(e == s), b, oh};
    endfunction

    // One clock: apply inputs, advance model at the edge, check after it.
    task automatic step(input logic r, input logic v, input logic [1:0] c);
        logic [5:0] exp_a, exp_b, got_a, got_b;
        bit prev_busy_a, prev_busy_b;
        @(negedge clk);
        rst   = r;
        valid = v;
        {in1, in0} = c;
        @(posedge clk);
        edge_n++;
        prev_busy_a = (edge_n - 1 >= start_a) && (edge_n - 1 < start_a + 4);
        prev_busy_b = (edge_n - 1 >= start_b) && (edge_n - 1 < start_b + 1);
        if (r) begin
            start_a = -1000;
            start_b = -1000;
        end else if (v) begin
            if (RETRIG || !prev_busy_a) begin
                start_a = edge_n;
                code_a  = int'(c);
            end
            if (RETRIG || !prev_busy_b) begin
                start_b = edge_n;
                code_b  = int'(c);
            end
        end
        #1;
        exp_a = expect_vec(edge_n, start_a, code_a, 4);
        exp_b = expect_vec(edge_n, start_b, code_b, 1);
        got_a = {ack_a, busy_a, o3_a, o2_a, o1_a, o0_a};
        got_b = {ack_b, busy_b, o3_b, o2_b, o1_b, o0_b};
        checks++;
        assert (got_a === exp_a) else begin
            errors++;
            $error("FAIL h4 edge %0d ack/busy/out3..0 got %b exp %b", edge_n, got_a, exp_a);
        end
        checks++;
        assert (got_b === exp_b) else begin
            errors++;
            $error("FAIL h1 edge %0d ack/busy/out3..0 got %b exp %b", edge_n, got_b, exp_b);
        end
        checks++;
        assert ($countones(got_a[3:0]) <= 1 && $countones(got_b[3:0]) <= 1) else begin
            errors++;
            $error("FAIL onehot edge %0d got %b/%b exp at most one bit", edge_n, got_a[3:0], got_b[3:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; in0 = 1'b0; in1 = 1'b0;

        // Reset held two cycles with valid and code 11 present.
        step(1'b1, 1'b1, 2'b11);
        step(1'b1, 1'b1, 2'b11);
        idle(1);

        // Basic pulse on code 10.
        step(1'b0, 1'b1, 2'b10);
        idle(6);

        // Decode sweep, each code offered while idle.
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 2'(c));
            idle(5);
        end

        // Code 01 accepted, code 11 offered two cycles later.
        step(1'b0, 1'b1, 2'b01);
        idle(1);
        step(1'b0, 1'b1, 2'b11);
        idle(8);

        // Reset during the second hold cycle of code 11, then a fresh accept.
        step(1'b0, 1'b1, 2'b11);
        idle(1);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b01);
        idle(5);

        // Valid held high on code 00: the H=1 instance toggles on/off.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 2'b00);
        idle(5);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_pulse.md
# decoder_pulse

Registered 2-to-4 decoder with a timed one-hot output pulse, the receiving end of the 4-to-2 priority encoder path. It accepts a 2-bit code qualified by `valid` and drives the matching one-hot line for a programmable number of cycles. While the pulse is active it reports `busy`. It sits between the encoder outputs (or a switch bank) and LED/enable lines on the lab board.

## Interface
- `HOLD_CYCLES`, default 4: number of clock cycles a decoded one-hot output stays asserted. Legal range is 1..255.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in0` input 1: code bit 0 (LSB), matching encoder `out0`.
- `in1` input 1: code bit 1 (MSB), matching encoder `out1`.
- `valid` input 1: `in1:in0` is presented for acceptance this cycle.
- `ack` output 1: one-cycle pulse, the cycle after a code is accepted.
- `busy` output 1: high while a pulse is being held.
- `out0` output 1: one-hot line for code 00.
- `out1` output 1: one-hot line for code 01.
- `out2` output 1: one-hot line for code 10.
- `out3` output 1: one-hot line for code 11.

## Operation
- FSM has two states: IDLE and HOLD.
- **IDLE**
  - `out0..out3` = 0, `busy` = 0.
  - When `valid` = 1 at a rising edge, the code `{in1,in0}` is captured into a 2-bit register.
  - The counter is loaded with `HOLD_CYCLES-1` and the FSM goes to HOLD.
  - `ack` is 1 in the following cycle.
- **HOLD**
  - `out[code]` = 1, all other outputs = 0, `busy` = 1.
  - The counter decrements each cycle.
  - When the counter is 0 at a rising edge, the FSM returns to IDLE.
- `valid` during HOLD: behaviour is set by the configuration macro (see Configuration).
- Counter is 8 bits and unsigned. It never wraps: the decrement happens only while the counter is nonzero.
- Outputs are registered: they are decoded from the state and code registers, never from the inputs directly. At most one of `out0..out3` is ever high.
- Code decode mapping: 00→`out0`, 01→`out1`, 10→`out2`, 11→`out3`. Every 2-bit value is legal, so there is no default or error case.
- **Reset**
  - `rst` = 1 at a rising edge forces IDLE, code = 00, counter = 0, and all outputs = 0 (`ack`, `busy`, `out0..out3`).
  - `rst` takes priority over `valid` in the same cycle.
  - Reset in the middle of a HOLD ends the pulse at the next edge.

## Timing
- Code accepted at edge N:
  - `ack` = 1 during N→N+1 only.
  - `out[code]` and `busy` = 1 from edge N+1 through edge N+`HOLD_CYCLES`, i.e. exactly `HOLD_CYCLES` cycles.
  - Both return to 0 after edge N+`HOLD_CYCLES`.
- `HOLD_CYCLES` = 1 gives a single-cycle pulse, with `ack` and `out[code]` high in the same cycle.
- Back-to-back acceptance from IDLE:
  - A `valid` sampled at the edge where HOLD exits to IDLE is not accepted.
  - The earliest new acceptance is the edge after `busy` falls.
  - This leaves a guaranteed minimum of one idle cycle between pulses.
- Input-to-output latency is one cycle. There is no combinational path from `in*` or `valid` to any output.

## Configuration
- Macro: `DECODER_PULSE_RETRIGGER_EN`.
- **Defined:**
  - `valid` = 1 in HOLD recaptures the code, reloads the counter with `HOLD_CYCLES-1`, and pulses `ack`.
  - The output switches to the new one-hot line one cycle after the edge, with no gap.
  - `busy` stays high continuously.
- **Not defined:**
  - `valid` in HOLD is ignored: no `ack`, and code and counter are unchanged.
  - The current pulse completes its full length.

## Test plan
- **Reset:** hold `rst` = 1 for 2 cycles while `valid` = 1 and code = 11 -> all outputs stay 0. After release, the FSM is in IDLE.
- **Basic pulse:** `HOLD_CYCLES` = 4, code 10 with `valid` at edge N -> `ack` = 1 for one cycle; `out2` = 1 and `busy` = 1 for exactly 4 cycles from N+1; `out0`, `out1`, `out3` stay 0 throughout.
- **Full decode sweep:** codes 00, 01, 10, 11 in sequence, each presented when `busy` = 0 -> one-hot results `out0`, `out1`, `out2`, `out3` respectively, with never more than one output high.
- **Valid while busy:**
  - Code 01 accepted, then code 11 presented 2 cycles later.
  - Without macro -> `out1` completes 4 cycles and `out3` never asserts.
  - With macro -> `out3` asserts at the next edge, holds 4 cycles, and `busy` has no gap.
- **Reset mid-pulse:** `rst` asserted in the 2nd HOLD cycle of code 11 -> `out3` and `busy` are 0 after that edge, and the next `valid` is accepted normally.
- **Minimum hold:** `HOLD_CYCLES` = 1 with `valid` held high continuously, macro undefined -> `out0` pulses 1 cycle on, 1 cycle off, repeating.
